// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: tracks in-flight writers in EX/MEM/WB
// and drives FE/DE stall, DE flush, EX bubble and EX operand forwarding selects.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter bit RF_BYPASS    = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             de_valid_i,
   input  logic [4:0]       de_rs0_i,
   input  logic [4:0]       de_rs1_i,
   input  logic             de_use_rs0_i,
   input  logic             de_use_rs1_i,
   input  logic [4:0]       de_rd_i,
   input  logic             de_rf_we_i,
   input  logic             de_mem2rf_i,
   input  logic             ex_br_taken_i,
   output logic             fe_stall_o,
   output logic             de_stall_o,
   output logic             de_flush_o,
   output logic             ex_bubble_o,
   output logic [1:0]       fwd0_sel_o,
   output logic [1:0]       fwd1_sel_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } slot_t;

   // Remaining flush cycles after the branch cycle; a single-cycle flush never enters FLUSH.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2:0]       flush_left_r;
   slot_t            ex_slot_r;
   slot_t            mem_slot_r;
   slot_t            wb_slot_r;
   slot_t            de_slot_s;
   logic             load_use_s;
   logic             issue_s;

   function automatic logic slot_match(input slot_t s, input logic [4:0] rs, input logic use_rs);
      return s.vld && s.we && (s.rd != 5'd0) && (s.rd == rs) && use_rs;
   endfunction

   // Nearest producer wins; a load in EX is handled by the stall, never by forwarding.
   function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s, input slot_t wb_s,
                                          input logic [4:0] rs, input logic use_rs);
      logic [1:0] sel;
      if (slot_match(ex_s, rs, use_rs) && !ex_s.ld) begin
         sel = 2'b01;
      end else if (slot_match(mem_s, rs, use_rs)) begin
         sel = 2'b10;
      end else if (!RF_BYPASS && slot_match(wb_s, rs, use_rs)) begin
         sel = 2'b11;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign load_use_s = de_valid_i && ex_slot_r.ld &&
                       (slot_match(ex_slot_r, de_rs0_i, de_use_rs0_i) ||
                        slot_match(ex_slot_r, de_rs1_i, de_use_rs1_i));
   assign issue_s    = de_valid_i && !de_stall_o && !de_flush_o;
   assign de_slot_s  = '{vld: 1'b1, rd: de_rd_i, we: de_rf_we_i, ld: de_mem2rf_i};
   assign state_o    = state_r;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a taken branch overrides any load-use stall
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN, ST_STALL: begin
            if (ex_br_taken_i) begin
               state_nxt_s = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            end else if (load_use_s) begin
               state_nxt_s = ST_STALL;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (ex_br_taken_i) begin
               state_nxt_s = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            end else if (flush_left_r <= 3'd1) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: state_nxt_s = ST_RUN;
      endcase
   end

   // FSM outputs: flush first, then stall; DE input is ignored while flushing
   always_comb begin
      fe_stall_o = 1'b0;
      de_stall_o = 1'b0;
      de_flush_o = 1'b0;
      if (ex_br_taken_i || (state_r == ST_FLUSH)) begin
         de_flush_o = 1'b1;
      end else if (load_use_s) begin
         fe_stall_o = 1'b1;
         de_stall_o = 1'b1;
      end else begin
         de_flush_o = 1'b0;
      end
   end

   // Flush length counter, reloaded by every taken branch
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_left_r <= 3'd0;
      end else if (ex_br_taken_i) begin
         flush_left_r <= FLUSH_RELOAD;
      end else if ((state_r == ST_FLUSH) && (flush_left_r != 3'd0)) begin
         flush_left_r <= flush_left_r - 3'd1;
      end else begin
         flush_left_r <= flush_left_r;
      end
   end

   // In-flight writer slots plus registered EX bubble and forwarding selects
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot_r   <= '0;
         mem_slot_r  <= '0;
         wb_slot_r   <= '0;
         ex_bubble_o <= 1'b0;
         fwd0_sel_o  <= 2'b00;
         fwd1_sel_o  <= 2'b00;
      end else begin
         ex_slot_r   <= issue_s ? de_slot_s : slot_t'(8'd0);
         mem_slot_r  <= ex_slot_r;
         wb_slot_r   <= mem_slot_r;
         ex_bubble_o <= !issue_s;
         fwd0_sel_o  <= issue_s ? fwd_sel(ex_slot_r, mem_slot_r, wb_slot_r, de_rs0_i, de_use_rs0_i) : 2'b00;
         fwd1_sel_o  <= issue_s ? fwd_sel(ex_slot_r, mem_slot_r, wb_slot_r, de_rs1_i, de_use_rs1_i) : 2'b00;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_o <= {CNT_W{1'b0}};
         flush_cnt_o <= {CNT_W{1'b0}};
      end else begin
         if (de_stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_o <= stall_cnt_o;
         end
         if (de_flush_o && (flush_cnt_o != {CNT_W{1'b1}})) begin
            flush_cnt_o <= flush_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_o <= flush_cnt_o;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a scoreboard checks forwarding selects of every
// instruction reaching EX; inline checks cover stall/flush/state/counter behaviour.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       de_valid, use0, use1, we, ld, br;
   logic [4:0] rs0, rs1, rd;

   logic        fe_stall, de_stall, de_flush, ex_bubble;
   logic [1:0]  fwd0, fwd1, state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        fe_stall2, de_stall2, de_flush2, ex_bubble2;
   logic [1:0]  fwd0_2, fwd1_2, state2;
   logic [2:0]  stall_cnt2, flush_cnt2;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .RF_BYPASS(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .de_valid_i(de_valid), .de_rs0_i(rs0), .de_rs1_i(rs1),
      .de_use_rs0_i(use0), .de_use_rs1_i(use1), .de_rd_i(rd), .de_rf_we_i(we),
      .de_mem2rf_i(ld), .ex_br_taken_i(br), .fe_stall_o(fe_stall), .de_stall_o(de_stall),
      .de_flush_o(de_flush), .ex_bubble_o(ex_bubble), .fwd0_sel_o(fwd0), .fwd1_sel_o(fwd1),
      .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

   hazard_ctrl #(.FLUSH_CYCLES(2), .RF_BYPASS(1'b0), .CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .de_valid_i(de_valid), .de_rs0_i(rs0), .de_rs1_i(rs1),
      .de_use_rs0_i(use0), .de_use_rs1_i(use1), .de_rd_i(rd), .de_rf_we_i(we),
      .de_mem2rf_i(ld), .ex_br_taken_i(br), .fe_stall_o(fe_stall2), .de_stall_o(de_stall2),
      .de_flush_o(de_flush2), .ex_bubble_o(ex_bubble2), .fwd0_sel_o(fwd0_2), .fwd1_sel_o(fwd1_2),
      .state_o(state2), .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] d, input logic [4:0] s0, input logic [4:0] s1,
                        input logic u0, input logic u1, input logic w, input logic l, input logic b);
      de_valid = v; rd = d; rs0 = s0; rs1 = s1;
      use0 = u0; use1 = u1; we = w; ld = l; br = b;
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Scoreboard monitor: every instruction present in EX pops one expected {fwd0, fwd1}
   always @(negedge clk) begin
      if (mon_en && (ex_bubble === 1'b0)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ex_issue: got unexpected instr fwd=%b/%b expected none", fwd0, fwd1);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if ({fwd0, fwd1} !== e) begin
               errors++;
               $display("FAIL ex_fwd: got %b expected %b", {fwd0, fwd1}, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_bubble", 32'(ex_bubble), 32'd0);
      chk("rst_fwd", 32'({fwd0, fwd1}), 32'd0);
      chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
      chk("rst_comb", 32'({fe_stall, de_stall, de_flush}), 32'd0);
      rst = 1'b0;
      idle(1);
      chk("idle_bubble", 32'(ex_bubble), 32'd1);
      mon_en = 1'b1;

      // back-to-back ALU dependency forwards from MEM
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0000); tick();
      drive(1'b1, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("alu_nostall", 32'({fe_stall, de_stall}), 32'd0);
      exp_q.push_back(4'b0100); tick();
      // x0 writer then x0 reader: no hazard
      drive(1'b1, 5'd0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0000); tick();
      drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("x0_nostall", 32'({fe_stall, de_stall}), 32'd0);
      exp_q.push_back(4'b0000); tick();
      idle(3);

      // load-use: one stall cycle, then forward from WB
      drive(1'b1, 5'd5, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'b0000); tick();
      drive(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("lu_stall", 32'({fe_stall, de_stall, de_flush}), 32'b110);
      tick();
      chk("lu_state_stall", 32'(state), 32'd1);
      chk("lu_bubble", 32'(ex_bubble), 32'd1);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      chk("lu_released", 32'({fe_stall, de_stall}), 32'd0);
      exp_q.push_back(4'b1010); tick();
      chk("lu_state_run", 32'(state), 32'd0);
      chk("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);
      idle(3);

      // writer three ahead: WB-slot forward only without RF bypass
      drive(1'b1, 5'd8, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0000); tick();
      idle(2);
      drive(1'b1, 5'd10, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'b0000); tick();
      chk("wb_fwd_nobypass", 32'({fwd0_2, fwd1_2}), 32'b1100);
      idle(3);

      // taken branch coinciding with load-use: flush wins, two bubbles
      drive(1'b1, 5'd5, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'b0000); tick();
      drive(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("br_lu_comb", 32'({fe_stall, de_stall, de_flush}), 32'b001);
      tick();
      chk("br_state_flush", 32'(state), 32'd2);
      chk("br_bubble1", 32'(ex_bubble), 32'd1);
      drive(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("br_flush2_comb", 32'({fe_stall, de_stall, de_flush}), 32'b001);
      tick();
      chk("br_state_run", 32'(state), 32'd0);
      chk("br_bubble2", 32'(ex_bubble), 32'd1);
      chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
      idle(1);
      chk("br_flush_off", 32'(de_flush), 32'd0);
      idle(2);

      // reset in first FLUSH cycle
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("rst_fl_pre", 32'(state), 32'd2);
      mon_en = 1'b0;
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("rst_fl_state", 32'(state), 32'd0);
      chk("rst_fl_regs", 32'({ex_bubble, fwd0, fwd1}), 32'd0);
      chk("rst_fl_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
      chk("rst_fl_comb", 32'({fe_stall, de_stall, de_flush}), 32'd0);
      rst = 1'b0;

      // flush counter saturation on the narrow instance
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      mon_en = 1'b1;
      for (int i = 1; i < 7; i++) tick();
      chk("sat_reach", 32'(flush_cnt2), 32'd7);
      tick(); tick();
      chk("sat_hold", 32'(flush_cnt2), 32'd7);
      chk("sat_wide", 32'(flush_cnt), 32'd9);
      idle(1);
      chk("sat_tail_wide", 32'(flush_cnt), 32'd10);
      chk("sat_tail_narrow", 32'(flush_cnt2), 32'd7);
      chk("sat_state_run", 32'(state), 32'd0);
      idle(2);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
